// File: rtl/krnl_partialknn_buf_pkg.sv
// Shared FSM encoding and read-FIFO sizing for the partialKnn local buffer streamer.
// The FIFO must hold every in-flight URAM read plus a skid slot, hence lat+2.
package krnl_partialknn_buf_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_READ  = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_LOAD  = ST_LOAD,
        S_READ  = ST_READ,
        S_DRAIN = ST_DRAIN,
        S_DONE  = ST_DONE
    } buf_state_e;

    function automatic int fifo_depth(input int lat);
        return lat + 2;
    endfunction

endpackage

// File: rtl/krnl_partialknn_rd_skid_fifo.sv
// Purpose: small circular FIFO catching URAM read data ahead of the output stream.
// Latency: a pushed word is visible on o_pop_dat the cycle after the push; outputs depend only on registers.
// Backpressure: no push-side ready; the caller's credit scheme guarantees it never pushes into a full FIFO.
module krnl_partialknn_rd_skid_fifo #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 256,
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_push_vld,
    input  logic [DATA_WIDTH-1:0] i_push_dat,
    input  logic                  i_pop_rdy,
    output logic                  o_pop_vld,
    output logic [DATA_WIDTH-1:0] o_pop_dat,
    output logic [CNT_W-1:0]      o_cnt
);

    localparam int              PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0]   LAST_IDX = PW'(DEPTH - 1);
    localparam logic [PW-1:0]   P_ONE    = PW'(1);
    localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_FULL  = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]         r_wr_idx;
    logic [PW-1:0]         r_rd_idx;
    logic [CNT_W-1:0]      r_cnt;
    logic                  w_push;
    logic                  w_pop;

    assign o_pop_vld = (r_cnt != '0);
    assign o_pop_dat = r_mem[r_rd_idx];
    assign o_cnt     = r_cnt;
    assign w_pop     = o_pop_vld && i_pop_rdy;
    assign w_push    = i_push_vld && ((r_cnt != C_FULL) || w_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_idx <= '0;
            r_rd_idx <= '0;
            r_cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_idx] <= i_push_dat;
                r_wr_idx        <= (r_wr_idx == LAST_IDX) ? '0 : r_wr_idx + P_ONE;
            end
            if (w_pop) begin
                r_rd_idx <= (r_rd_idx == LAST_IDX) ? '0 : r_rd_idx + P_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + C_ONE;
                2'b01:   r_cnt <= r_cnt - C_ONE;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/krnl_partialknn_local_buf_streamer.sv
// Purpose: loads one stream into a single-port URAM bank, then streams it back; LOCAL_BUF_LAST_EN adds m_tlast.
// Latency: first m_tvalid READ_LATENCY+1 cycles after entering READ; 1 beat/cycle with m_tready held high.
// Backpressure: reads are issued only while in-flight reads plus FIFO occupancy leave room, so nothing is dropped.
module krnl_partialknn_local_buf_streamer
    import krnl_partialknn_buf_pkg::*;
#(
    parameter int DATA_WIDTH   = 256,
    parameter int ADDR_RANGE   = 2048,
    parameter int ADDR_WIDTH   = 11,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
`ifdef LOCAL_BUF_LAST_EN
    output logic                  m_tlast,
`endif
    input  logic                  m_tready,
    output logic [ADDR_WIDTH-1:0] address0,
    output logic                  ce0,
    output logic                  we0,
    output logic [DATA_WIDTH-1:0] d0,
    input  logic [DATA_WIDTH-1:0] q0
);

    localparam int                  FIFO_DEPTH = fifo_depth(READ_LATENCY);
    localparam int                  CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_WIDTH:0] MAX_LEN    = (ADDR_WIDTH + 1)'(ADDR_RANGE);
    localparam logic [ADDR_WIDTH-1:0] A_ONE    = ADDR_WIDTH'(1);
    localparam logic [CNT_W:0]      CREDIT_LIM = (CNT_W + 1)'(FIFO_DEPTH);

    buf_state_e            r_state;
    logic [ADDR_WIDTH-1:0] r_last_idx;
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH-1:0] r_out_cnt;
    logic [READ_LATENCY-1:0] r_rd_sr;

    logic [ADDR_WIDTH:0]   w_len_clamped;
    logic [ADDR_WIDTH-1:0] w_len_last;
    logic                  w_wr_fire;
    logic                  w_rd_fire;
    logic                  w_out_fire;
    logic                  w_credit;
    logic [CNT_W-1:0]      w_outstanding;
    logic [CNT_W-1:0]      w_fifo_cnt;
    logic [CNT_W:0]        w_inflight;
    logic                  w_fifo_vld;
    logic [DATA_WIDTH-1:0] w_fifo_dat;

    // Last index wraps correctly for a full-depth load: 0 - 1 == ADDR_RANGE-1 in ADDR_WIDTH bits.
    assign w_len_clamped = (length > MAX_LEN) ? MAX_LEN : length;
    assign w_len_last    = w_len_clamped[ADDR_WIDTH-1:0] - A_ONE;

    always_comb begin
        w_outstanding = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            w_outstanding = w_outstanding + CNT_W'(r_rd_sr[i]);
        end
    end

    assign w_inflight = {1'b0, w_outstanding} + {1'b0, w_fifo_cnt};
    assign w_credit   = (w_inflight < CREDIT_LIM);

    assign s_tready   = (r_state == S_LOAD);
    assign w_wr_fire  = s_tvalid && s_tready;
    assign w_rd_fire  = (r_state == S_READ) && w_credit;
    assign w_out_fire = w_fifo_vld && m_tready;

    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign ce0      = w_wr_fire || w_rd_fire;
    assign we0      = w_wr_fire;
    assign address0 = w_wr_fire ? r_wr_ptr : (w_rd_fire ? r_rd_ptr : '0);
    assign d0       = w_wr_fire ? s_tdata : '0;
    assign m_tvalid = w_fifo_vld;
    assign m_tdata  = w_fifo_dat;
`ifdef LOCAL_BUF_LAST_EN
    assign m_tlast  = w_fifo_vld && (r_out_cnt == r_last_idx);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_last_idx <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_last_idx <= w_len_last;
                        r_wr_ptr   <= '0;
                        r_rd_ptr   <= '0;
                        r_state    <= (w_len_clamped == '0) ? S_DONE : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_wr_fire) begin
                        if (r_wr_ptr == r_last_idx) begin
                            r_state <= S_READ;
                        end else begin
                            r_wr_ptr <= r_wr_ptr + A_ONE;
                        end
                    end
                end
                S_READ: begin
                    if (w_rd_fire) begin
                        if (r_rd_ptr == r_last_idx) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_rd_ptr <= r_rd_ptr + A_ONE;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_out_fire && (r_out_cnt == r_last_idx)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_cnt <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_out_cnt <= '0;
        end else if (w_out_fire && (r_out_cnt != r_last_idx)) begin
            r_out_cnt <= r_out_cnt + A_ONE;
        end
    end

    // Bit i set means a read issued i+1 cycles ago; the top bit marks q0 valid now.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_sr <= '0;
        end else begin
            r_rd_sr[0] <= w_rd_fire;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_rd_sr[i] <= r_rd_sr[i-1];
            end
        end
    end

    krnl_partialknn_rd_skid_fifo #(
        .DEPTH      (FIFO_DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_W      (CNT_W)
    ) u_rd_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_push_vld (r_rd_sr[READ_LATENCY-1]),
        .i_push_dat (q0),
        .i_pop_rdy  (m_tready),
        .o_pop_vld  (w_fifo_vld),
        .o_pop_dat  (w_fifo_dat),
        .o_cnt      (w_fifo_cnt)
    );

endmodule
